// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: forwarding, load-use stall, branch flush, debug halt drain
// Holds the instruction in F and drains D..W into bubbles before acknowledging a halt.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             HaltReq,
  input  logic             CntClr,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             HaltAck,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q;
  logic [DCW-1:0]   drain_q;
  logic             halt_ack_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             lw_stall;
  logic             lw_eff;

  always_comb begin
    ForwardA_E = 2'b00;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == Rs1_E))      ForwardA_E = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == Rs1_E)) ForwardA_E = 2'b01;
    ForwardB_E = 2'b00;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == Rs2_E))      ForwardB_E = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == Rs2_E)) ForwardB_E = 2'b01;
  end

  assign lw_stall = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  // A taken branch squashes the D instruction anyway, so it overrides the load-use stall.
  assign lw_eff   = lw_stall && !PCSrcE;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    case (state_q)
      RUN: begin
        StallF = lw_eff;
        StallD = lw_eff;
        FlushE = lw_eff || PCSrcE;
        FlushD = PCSrcE;
      end
      DRAIN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_eff) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else begin
          StallF = 1'b1;
          FlushD = 1'b1;
        end
      end
      HALTED: begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      drain_q    <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (HaltReq && !lw_eff) begin
            state_q <= DRAIN;
            drain_q <= DCW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (!HaltReq) begin
            state_q <= RUN;
            drain_q <= '0;
          end else if (PCSrcE) begin
            drain_q <= DCW'(DRAIN_CYCLES - 1);
          end else if (lw_eff) begin
            drain_q <= drain_q;
          end else if (drain_q <= DCW'(1)) begin
            state_q    <= HALTED;
            drain_q    <= '0;
            halt_ack_q <= 1'b1;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        HALTED: begin
          if (!HaltReq) begin
            state_q    <= RUN;
            halt_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= RUN;
          drain_q    <= '0;
          halt_ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (CntClr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lw_stall && StallD && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (PCSrcE && (flush_cnt_q != '1))             flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign HaltAck    = halt_ack_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk, rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, PCSrcE, RegWriteM, RegWriteW, HaltReq, CntClr;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       StallF, StallD, FlushD, FlushE, HaltAck;
  logic [3:0] StallCount, FlushCount;
  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .HaltReq(HaltReq), .CntClr(CntClr),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .HaltAck(HaltAck), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; CntClr = 0;
  endtask

  task automatic set_lw();
    ResultSrcE = 1; RD_E = 7; Rs1_D = 7;
  endtask

  initial begin
    rst = 0; HaltReq = 0; clr_in();
    #3;
    chk("rst_haltack", HaltAck, 0);
    chk("rst_stallcnt", StallCount, 0);
    chk("rst_flushcnt", FlushCount, 0);
    chk("rst_fwda", ForwardA_E, 0);
    chk("rst_fwdb", ForwardB_E, 0);
    chk("rst_stallf", StallF, 0);
    chk("rst_stalld", StallD, 0);
    chk("rst_flushd", FlushD, 0);
    chk("rst_flushe", FlushE, 0);
    tick(); rst = 1;

    RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1; Rs1_E = 5; #1;
    chk("fwda_mem_prio", ForwardA_E, 2'b10);
    chk("fwdb_none", ForwardB_E, 2'b00);
    RD_M = 0; RD_W = 0; #1;
    chk("fwda_x0", ForwardA_E, 2'b00);
    RD_M = 3; RD_W = 9; Rs1_E = 9; Rs2_E = 3; #1;
    chk("fwda_wb", ForwardA_E, 2'b01);
    chk("fwdb_mem", ForwardB_E, 2'b10);
    RegWriteM = 0; RD_W = 3; #1;
    chk("fwdb_wb_mem_off", ForwardB_E, 2'b01);
    chk("fwda_nomatch", ForwardA_E, 2'b00);
    clr_in(); tick();

    ResultSrcE = 1; RD_E = 7; Rs2_D = 7; #1;
    chk("lw_stallf", StallF, 1);
    chk("lw_stalld", StallD, 1);
    chk("lw_flushe", FlushE, 1);
    chk("lw_flushd", FlushD, 0);
    tick();
    chk("lw_count", StallCount, 1);
    clr_in();
    ResultSrcE = 1; #1;
    chk("lw_rd0_nostall", StallF, 0);
    clr_in(); tick();

    set_lw(); PCSrcE = 1; #1;
    chk("prio_stallf", StallF, 0);
    chk("prio_stalld", StallD, 0);
    chk("prio_flushd", FlushD, 1);
    chk("prio_flushe", FlushE, 1);
    tick();
    chk("prio_flushcnt", FlushCount, 1);
    chk("prio_stallcnt", StallCount, 1);
    clr_in();

    HaltReq = 1; #1;
    chk("halt_req_ack0", HaltAck, 0);
    tick();
    chk("drain_stallf", StallF, 1);
    chk("drain_flushd", FlushD, 1);
    chk("drain_ack0", HaltAck, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_ack_wait", HaltAck, 0);
    end
    tick();
    chk("halted_ack", HaltAck, 1);
    chk("halted_stallf", StallF, 1);
    chk("halted_flushd", FlushD, 1);
    chk("halted_flushe", FlushE, 0);
    RD_M = 4; RegWriteM = 1; Rs2_E = 4; #1;
    chk("halted_fwdb", ForwardB_E, 2'b10);
    clr_in();
    HaltReq = 0; #1;
    chk("unhalt_ack_held", HaltAck, 1);
    tick();
    chk("unhalt_ack0", HaltAck, 0);
    chk("unhalt_stallf", StallF, 0);
    chk("unhalt_flushd", FlushD, 0);

    HaltReq = 1; tick(); tick();
    PCSrcE = 1; #1;
    chk("drain_br_stallf", StallF, 0);
    chk("drain_br_flushd", FlushD, 1);
    chk("drain_br_flushe", FlushE, 1);
    tick(); PCSrcE = 0;
    chk("drain_br_flushcnt", FlushCount, 2);
    tick(); chk("drain_br_ack_c1", HaltAck, 0);
    tick(); chk("drain_br_ack_c2", HaltAck, 0);
    tick(); chk("drain_br_ack_c3", HaltAck, 1);
    HaltReq = 0; tick();

    HaltReq = 1; tick();
    set_lw(); #1;
    chk("drain_lw_stallf", StallF, 1);
    chk("drain_lw_stalld", StallD, 1);
    chk("drain_lw_flushd", FlushD, 0);
    chk("drain_lw_flushe", FlushE, 1);
    tick(); clr_in();
    chk("drain_lw_cnt", StallCount, 2);
    repeat (3) tick();
    chk("drain_lw_hold_ack0", HaltAck, 0);
    tick();
    chk("drain_lw_hold_ack1", HaltAck, 1);
    HaltReq = 0; tick();

    HaltReq = 1; tick(); tick();
    HaltReq = 0; tick();
    chk("abandon_flushd", FlushD, 0);
    chk("abandon_stallf", StallF, 0);
    tick(); tick();
    chk("abandon_ack0", HaltAck, 0);

    HaltReq = 1; ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
    tick(); clr_in(); #1;
    chk("defer_still_run", FlushD, 0);
    chk("defer_stallcnt", StallCount, 3);
    tick();
    chk("defer_then_drain", FlushD, 1);
    HaltReq = 0; tick();

    set_lw();
    repeat (20) tick();
    chk("sat_stallcnt", StallCount, 15);
    CntClr = 1; tick();
    chk("clr_stallcnt", StallCount, 0);
    chk("clr_flushcnt", FlushCount, 0);
    clr_in();

    set_lw(); tick(); clr_in();
    PCSrcE = 1; tick(); clr_in();
    HaltReq = 1; repeat (5) tick();
    chk("pre_rst_ack", HaltAck, 1);
    chk("pre_rst_stallcnt", StallCount, 1);
    chk("pre_rst_flushcnt", FlushCount, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_ack", HaltAck, 0);
    chk("async_rst_stallcnt", StallCount, 0);
    chk("async_rst_flushcnt", FlushCount, 0);
    chk("async_rst_stallf", StallF, 0);
    HaltReq = 0; tick(); rst = 1; tick();
    chk("post_rst_ack", HaltAck, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
